// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_e;

  // Instruction fetches always go out as full-word reads.
  localparam size_e     INST_SIZE  = WORD;
  localparam logic [3:0] INST_WSTRB = 4'b0000;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side SRAM requests (inst + data) and the shared downstream port, bundled.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_wr;
  logic [1:0]        d_size;
  logic [3:0]        d_wstrb;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [DATA_W-1:0] d_rdata;

  logic              m_req;
  logic              m_wr;
  logic [1:0]        m_size;
  logic [3:0]        m_wstrb;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_rdata;

  // slave: the arbiter itself; master: the CPU requesters plus the downstream bridge.
  modport slave (
    input  i_req, i_addr,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_starve_ctr.sv
// Winner selection for the shared port: data first, unless the instruction
// side has already lost STARVE_MAX consecutive arbitrations.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_arb_en,
  input  logic   i_inst_req,
  input  logic   i_data_req,
  output owner_e o_winner
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_starved;

  assign w_starved = (r_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    o_winner = NONE;
    if (i_data_req && !(i_inst_req && w_starved)) begin
      o_winner = DATA;
    end else if (i_inst_req) begin
      o_winner = INST;
    end
  end

  // Counter only moves on arbitration cycles; it measures consecutive losses.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_arb_en) begin
      if (!i_inst_req || (o_winner == INST)) begin
        w_cnt_nxt = '0;
      end else if ((o_winner == DATA) && !w_starved) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch and data
// load/store, one outstanding transaction at a time, with flush support.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  mem_port_arbiter_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  owner_e            r_owner;
  owner_e            w_owner_nxt;
  logic              r_discard;
  logic              w_discard_nxt;

  logic              r_wr;
  size_e             r_size;
  logic [3:0]        r_wstrb;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  owner_e            w_winner;
  logic              w_arb_en;
  logic              w_inst_req;
  logic              w_inst_flush;
  logic              w_m_req;
  logic              w_i_addr_ok;
  logic              w_d_addr_ok;
  logic              w_i_data_ok;
  logic              w_d_data_ok;

  assign w_arb_en     = (r_state == IDLE);
  assign w_inst_req   = bus.i_req && !flush;
  assign w_inst_flush = flush && (r_owner == INST);

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .i_arb_en   (w_arb_en),
    .i_inst_req (w_inst_req),
    .i_data_req (bus.d_req),
    .o_winner   (w_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= NONE;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_discard_nxt = r_discard;
    w_i_addr_ok   = 1'b0;
    w_d_addr_ok   = 1'b0;
    w_i_data_ok   = 1'b0;
    w_d_data_ok   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_winner != NONE) begin
          w_state_nxt = ADDR;
          w_owner_nxt = w_winner;
        end
      end
      ADDR: begin
        if (bus.m_addr_ok) begin
          w_state_nxt = WAIT;
          if (r_owner == DATA) begin
            w_d_addr_ok = 1'b1;
          end else if (w_inst_flush) begin
            // Downstream already took it: let it finish, but swallow the response.
            w_discard_nxt = 1'b1;
          end else if (r_owner == INST) begin
            w_i_addr_ok = 1'b1;
          end
        end else if (w_inst_flush) begin
          w_state_nxt = IDLE;
          w_owner_nxt = NONE;
        end
      end
      WAIT: begin
        if (bus.m_data_ok) begin
          w_state_nxt   = IDLE;
          w_owner_nxt   = NONE;
          w_discard_nxt = 1'b0;
          if (r_owner == DATA) begin
            w_d_data_ok = 1'b1;
          end else if ((r_owner == INST) && !r_discard && !w_inst_flush) begin
            w_i_data_ok = 1'b1;
          end
        end else if (w_inst_flush) begin
          w_discard_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_owner_nxt = NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_size  <= BYTE;
      r_wstrb <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_arb_en && (w_winner == DATA)) begin
      r_wr    <= bus.d_wr;
      r_size  <= size_e'(bus.d_size);
      r_wstrb <= bus.d_wstrb;
      r_addr  <= bus.d_addr;
      r_wdata <= bus.d_wdata;
    end else if (w_arb_en && (w_winner == INST)) begin
      r_wr    <= 1'b0;
      r_size  <= INST_SIZE;
      r_wstrb <= INST_WSTRB;
      r_addr  <= bus.i_addr;
      r_wdata <= '0;
    end
  end

  // Request fields are only visible while the request is actually presented.
  assign w_m_req     = (r_state == ADDR);
  assign bus.m_req   = w_m_req;
  assign bus.m_wr    = w_m_req && r_wr;
  assign bus.m_size  = w_m_req ? r_size : BYTE;
  assign bus.m_wstrb = w_m_req ? r_wstrb : '0;
  assign bus.m_addr  = w_m_req ? r_addr : '0;
  assign bus.m_wdata = w_m_req ? r_wdata : '0;

  assign bus.i_addr_ok = w_i_addr_ok;
  assign bus.d_addr_ok = w_d_addr_ok;
  assign bus.i_data_ok = w_i_data_ok;
  assign bus.d_data_ok = w_d_data_ok;
  assign bus.i_rdata   = w_i_data_ok ? bus.m_rdata : '0;
  assign bus.d_rdata   = (w_d_data_ok && !r_wr) ? bus.m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level priority/starvation model.
module tb_mem_port_arbiter;

  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations from one downstream-served transaction.
  bit          s_ok;
  logic [1:0]  s_who;
  logic        s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_mreq_wait;
  logic        s_idok;
  logic        s_ddok;
  logic [31:0] s_ird;
  logic [31:0] s_drd;

  // Plays the downstream bridge for one transaction; s_who = {d_addr_ok, i_addr_ok}.
  task automatic serve(input logic [31:0] rdata, input int lat_a, input int lat_d, input bit drop);
    int n;
    s_ok = 1'b0;
    s_who = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!bus.m_req && n < 20);
    if (!bus.m_req) return;
    s_wr = bus.m_wr;
    s_size = bus.m_size;
    s_wstrb = bus.m_wstrb;
    s_addr = bus.m_addr;
    s_wdata = bus.m_wdata;
    repeat (lat_a) @(negedge clk);
    bus.m_addr_ok = 1'b1;
    #1;
    s_who = {bus.d_addr_ok, bus.i_addr_ok};
    if (drop && bus.i_addr_ok) bus.i_req = 1'b0;
    if (drop && bus.d_addr_ok) bus.d_req = 1'b0;
    @(negedge clk);
    bus.m_addr_ok = 1'b0;
    #1;
    s_mreq_wait = bus.m_req;
    repeat (lat_d) @(negedge clk);
    bus.m_data_ok = 1'b1;
    bus.m_rdata = rdata;
    #1;
    s_idok = bus.i_data_ok;
    s_ddok = bus.d_data_ok;
    s_ird = bus.i_rdata;
    s_drd = bus.d_rdata;
    s_ok = 1'b1;
    @(negedge clk);
    bus.m_data_ok = 1'b0;
    bus.m_rdata = '0;
  endtask

  task automatic test_reset();
    logic [145:0] outs;
    rst = 1'b1;
    flush = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h1234_5678;
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_size = 2'd2; bus.d_wstrb = 4'hF;
    bus.d_addr = 32'h8000_0000; bus.d_wdata = 32'hFFFF_FFFF;
    bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    outs = {bus.m_req, bus.m_wr, bus.m_size, bus.m_wstrb, bus.m_addr, bus.m_wdata,
            bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok, bus.i_rdata, bus.d_rdata};
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.m_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_req !== 1'b0) begin n_bad++; $display("FAIL reset_idle_mreq: got %b want 0", bus.m_req); end
  endtask

  task automatic test_inst_read();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'hBFC0_0000;
    #1;
    n_cmp++;
    if (bus.m_req !== 1'b0) begin n_bad++; $display("FAIL inst_c0_mreq: got %b want 0", bus.m_req); end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.m_req, bus.m_wr, bus.m_addr} !== {2'b10, 32'hBFC0_0000}) begin
      n_bad++; $display("FAIL inst_c1_req: got %b/%b/%h want 1/0/bfc00000", bus.m_req, bus.m_wr, bus.m_addr);
    end
    n_cmp++;
    if (bus.i_addr_ok !== 1'b0) begin n_bad++; $display("FAIL inst_c1_addr_ok: got %b want 0", bus.i_addr_ok); end
    @(negedge clk);
    bus.m_addr_ok = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i_addr_ok, bus.d_addr_ok} !== 2'b10) begin
      n_bad++; $display("FAIL inst_c2_addr_ok: got i=%b d=%b want i=1 d=0", bus.i_addr_ok, bus.d_addr_ok);
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    bus.m_addr_ok = 1'b0;
    #1;
    n_cmp++;
    if ({bus.m_req, bus.i_data_ok} !== 2'b00) begin
      n_bad++; $display("FAIL inst_c3_wait: got mreq=%b dok=%b want 0 0", bus.m_req, bus.i_data_ok);
    end
    @(negedge clk);
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'h3C08_BFC0;
    #1;
    n_cmp++;
    if ({bus.i_data_ok, bus.i_rdata} !== {1'b1, 32'h3C08_BFC0}) begin
      n_bad++; $display("FAIL inst_c4_data: got %b/%h want 1/3c08bfc0", bus.i_data_ok, bus.i_rdata);
    end
    n_cmp++;
    if ({bus.d_addr_ok, bus.d_data_ok, bus.d_rdata} !== '0) begin
      n_bad++; $display("FAIL inst_c4_d_quiet: got %b/%b/%h want 0/0/0", bus.d_addr_ok, bus.d_data_ok, bus.d_rdata);
    end
    @(negedge clk);
    bus.m_data_ok = 1'b0; bus.m_rdata = '0;
    #1;
    n_cmp++;
    if ({bus.i_data_ok, bus.i_rdata} !== '0) begin
      n_bad++; $display("FAIL inst_c5_idle: got %b/%h want 0/0", bus.i_data_ok, bus.i_rdata);
    end
  endtask

  task automatic test_write_priority();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h0040_0000;
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_size = 2'd2; bus.d_wstrb = 4'hF;
    bus.d_addr = 32'h8000_1000; bus.d_wdata = 32'h1234_5678;
    serve(32'hDEAD_BEEF, 0, 0, 1'b1);
    n_cmp++;
    if (!s_ok || s_who !== 2'b10) begin n_bad++; $display("FAIL prio_first_owner: got ok=%0d who=%b want 1 10", s_ok, s_who); end
    n_cmp++;
    if ({s_wr, s_size, s_wstrb, s_addr, s_wdata} !== {1'b1, 2'd2, 4'hF, 32'h8000_1000, 32'h1234_5678}) begin
      n_bad++; $display("FAIL prio_write_fields: got %b %0d %h %h %h want 1 2 f 80001000 12345678", s_wr, s_size, s_wstrb, s_addr, s_wdata);
    end
    n_cmp++;
    if ({s_ddok, s_drd, s_idok, s_ird} !== {1'b1, 32'h0, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL prio_write_done: got d=%b/%h i=%b/%h want d=1/0 i=0/0", s_ddok, s_drd, s_idok, s_ird);
    end
    serve(32'h2408_0001, 0, 1, 1'b1);
    n_cmp++;
    if (!s_ok || s_who !== 2'b01) begin n_bad++; $display("FAIL prio_second_owner: got ok=%0d who=%b want 1 01", s_ok, s_who); end
    n_cmp++;
    if ({s_wr, s_addr, s_idok, s_ird} !== {1'b0, 32'h0040_0000, 1'b1, 32'h2408_0001}) begin
      n_bad++; $display("FAIL prio_inst_read: got %b %h %b %h want 0 00400000 1 24080001", s_wr, s_addr, s_idok, s_ird);
    end
  endtask

  task automatic test_starvation();
    logic [1:0] exp_seq[10];
    int lost;
    lost = 0;
    for (int k = 0; k < 10; k++) begin
      if (lost == int'(SMAX)) begin exp_seq[k] = 2'b01; lost = 0; end
      else begin exp_seq[k] = 2'b10; lost++; end
    end
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0100;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h0000_2000;
    for (int k = 0; k < 10; k++) begin
      serve(32'(k), 0, 0, 1'b0);
      n_cmp++;
      if (!s_ok || s_who !== exp_seq[k]) begin
        n_bad++; $display("FAIL starve_grant_%0d: got ok=%0d who=%b want %b", k, s_ok, s_who, exp_seq[k]);
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
  endtask

  task automatic test_flush_addr();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_1000;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.m_req !== 1'b1) begin n_bad++; $display("FAIL flushaddr_mreq: got %b want 1", bus.m_req); end
    flush = 1'b1;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd1; bus.d_wstrb = 4'h0; bus.d_addr = 32'h0000_2002;
    #1;
    n_cmp++;
    if (bus.i_addr_ok !== 1'b0) begin n_bad++; $display("FAIL flushaddr_no_addr_ok: got %b want 0", bus.i_addr_ok); end
    @(negedge clk);
    flush = 1'b0; bus.i_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_req !== 1'b0) begin n_bad++; $display("FAIL flushaddr_mreq_drop: got %b want 0", bus.m_req); end
    serve(32'h0000_55AA, 0, 0, 1'b1);
    n_cmp++;
    if (!s_ok || s_who !== 2'b10 || s_addr !== 32'h0000_2002 || s_size !== 2'd1) begin
      n_bad++; $display("FAIL flushaddr_data_next: got ok=%0d who=%b addr=%h size=%0d want 1 10 00002002 1", s_ok, s_who, s_addr, s_size);
    end
    n_cmp++;
    if ({s_ddok, s_drd} !== {1'b1, 32'h0000_55AA}) begin
      n_bad++; $display("FAIL flushaddr_data_rd: got %b/%h want 1/000055aa", s_ddok, s_drd);
    end
  endtask

  task automatic test_flush_wait();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_3000;
    @(negedge clk);
    bus.m_addr_ok = 1'b1;
    #1;
    n_cmp++;
    if (bus.i_addr_ok !== 1'b1) begin n_bad++; $display("FAIL flushwait_addr_ok: got %b want 1", bus.i_addr_ok); end
    bus.i_req = 1'b0;
    @(negedge clk);
    bus.m_addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0000_CAFE;
    #1;
    n_cmp++;
    if ({bus.i_data_ok, bus.i_rdata, bus.d_data_ok} !== '0) begin
      n_bad++; $display("FAIL flushwait_silent: got %b/%h/%b want 0/0/0", bus.i_data_ok, bus.i_rdata, bus.d_data_ok);
    end
    @(negedge clk);
    bus.m_data_ok = 1'b0; bus.m_rdata = '0;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_3004;
    serve(32'h0000_1111, 0, 0, 1'b1);
    n_cmp++;
    if (!s_ok || s_who !== 2'b01 || {s_idok, s_ird} !== {1'b1, 32'h0000_1111}) begin
      n_bad++; $display("FAIL flushwait_next: got ok=%0d who=%b %b/%h want 1 01 1/00001111", s_ok, s_who, s_idok, s_ird);
    end
    // flush coinciding with m_addr_ok: accepted downstream, hidden upstream
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_3008;
    @(negedge clk);
    bus.m_addr_ok = 1'b1; flush = 1'b1;
    #1;
    n_cmp++;
    if ({bus.m_req, bus.i_addr_ok} !== 2'b10) begin
      n_bad++; $display("FAIL flushacc_addr_ok: got mreq=%b aok=%b want 1 0", bus.m_req, bus.i_addr_ok);
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    bus.m_addr_ok = 1'b0; flush = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0000_0BAD;
    #1;
    n_cmp++;
    if ({bus.i_data_ok, bus.i_rdata} !== '0) begin
      n_bad++; $display("FAIL flushacc_silent: got %b/%h want 0/0", bus.i_data_ok, bus.i_rdata);
    end
    @(negedge clk);
    bus.m_data_ok = 1'b0; bus.m_rdata = '0;
    // flush in the same cycle as m_data_ok
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_300C;
    @(negedge clk);
    bus.m_addr_ok = 1'b1;
    #1;
    bus.i_req = 1'b0;
    @(negedge clk);
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0000_7777; flush = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i_data_ok, bus.i_rdata} !== '0) begin
      n_bad++; $display("FAIL flushsame_silent: got %b/%h want 0/0", bus.i_data_ok, bus.i_rdata);
    end
    @(negedge clk);
    bus.m_data_ok = 1'b0; bus.m_rdata = '0; flush = 1'b0;
    // data transactions ignore flush entirely
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd0; bus.d_addr = 32'h0000_4001;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.m_req !== 1'b1) begin n_bad++; $display("FAIL flushdata_mreq: got %b want 1", bus.m_req); end
    bus.m_addr_ok = 1'b1;
    #1;
    n_cmp++;
    if (bus.d_addr_ok !== 1'b1) begin n_bad++; $display("FAIL flushdata_addr_ok: got %b want 1", bus.d_addr_ok); end
    bus.d_req = 1'b0;
    @(negedge clk);
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0000_0077;
    #1;
    n_cmp++;
    if ({bus.d_data_ok, bus.d_rdata} !== {1'b1, 32'h0000_0077}) begin
      n_bad++; $display("FAIL flushdata_done: got %b/%h want 1/00000077", bus.d_data_ok, bus.d_rdata);
    end
    @(negedge clk);
    bus.m_data_ok = 1'b0; bus.m_rdata = '0; flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [145:0] outs;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_size = 2'd1; bus.d_wstrb = 4'h3;
    bus.d_addr = 32'h0000_5000; bus.d_wdata = 32'h0000_A5A5;
    @(negedge clk);
    bus.m_addr_ok = 1'b1;
    #1;
    n_cmp++;
    if (bus.d_addr_ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_addr_ok: got %b want 1", bus.d_addr_ok); end
    bus.d_req = 1'b0;
    @(negedge clk);
    bus.m_addr_ok = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0000_0099;
    #1;
    outs = {bus.m_req, bus.m_wr, bus.m_size, bus.m_wstrb, bus.m_addr, bus.m_wdata,
            bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok, bus.i_rdata, bus.d_rdata};
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL rstmid_outputs: got %h want 0", outs); end
    @(negedge clk);
    bus.m_data_ok = 1'b0; bus.m_rdata = '0;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h0000_5004;
    serve(32'h0000_4242, 0, 0, 1'b1);
    n_cmp++;
    if (!s_ok || s_who !== 2'b10 || {s_ddok, s_drd} !== {1'b1, 32'h0000_4242}) begin
      n_bad++; $display("FAIL rstmid_next: got ok=%0d who=%b %b/%h want 1 10 1/00004242", s_ok, s_who, s_ddok, s_drd);
    end
  endtask

  // Transaction-level model: data wins unless inst has lost SMAX times in a row.
  task automatic test_random();
    bit          pi, pd;
    int          lost;
    logic [1:0]  exp_who;
    logic [31:0] ia, da, dw, rd;
    logic        dwr;
    logic [1:0]  dsz;
    logic [3:0]  dst;
    logic [75:0] exp_f;
    pi = 1'b0; pd = 1'b0; lost = 0;
    ia = '0; da = '0; dw = '0; dwr = 1'b0; dsz = '0; dst = '0;
    @(negedge clk);
    for (int t = 0; t < 60; t++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1'b1; ia = $urandom & 32'hFFFF_FFFC;
        bus.i_req = 1'b1; bus.i_addr = ia;
      end
      if (!pd && ($urandom_range(0, 1) == 1 || !pi)) begin
        pd = 1'b1; da = $urandom; dw = $urandom; dwr = 1'($urandom_range(0, 1));
        dsz = 2'($urandom_range(0, 2)); dst = 4'($urandom_range(0, 15));
        bus.d_req = 1'b1; bus.d_addr = da; bus.d_wdata = dw; bus.d_wr = dwr;
        bus.d_size = dsz; bus.d_wstrb = dst;
      end
      if (pi && pd) begin
        if (lost == int'(SMAX)) begin exp_who = 2'b01; lost = 0; end
        else begin exp_who = 2'b10; lost++; end
      end else if (pd) begin
        exp_who = 2'b10; lost = 0;
      end else begin
        exp_who = 2'b01; lost = 0;
      end
      exp_f = (exp_who == 2'b10) ? {dwr, dsz, dst, da, dw} : {1'b0, 2'd2, 4'h0, ia, 32'h0};
      rd = $urandom;
      serve(rd, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
      n_cmp++;
      if (!s_ok || s_who !== exp_who) begin
        n_bad++; $display("FAIL rand_owner_%0d: got ok=%0d who=%b want %b", t, s_ok, s_who, exp_who);
      end
      n_cmp++;
      if ({s_wr, s_size, s_wstrb, s_addr, s_wdata} !== exp_f) begin
        n_bad++; $display("FAIL rand_fields_%0d: got %h want %h", t, {s_wr, s_size, s_wstrb, s_addr, s_wdata}, exp_f);
      end
      n_cmp++;
      if (s_mreq_wait !== 1'b0) begin n_bad++; $display("FAIL rand_mreq_drop_%0d: got %b want 0", t, s_mreq_wait); end
      n_cmp++;
      if (exp_who == 2'b01) begin
        if ({s_idok, s_ird, s_ddok, s_drd} !== {1'b1, rd, 1'b0, 32'h0}) begin
          n_bad++; $display("FAIL rand_resp_%0d: got i=%b/%h d=%b/%h want i=1/%h d=0/0", t, s_idok, s_ird, s_ddok, s_drd, rd);
        end
        pi = 1'b0;
      end else begin
        if ({s_ddok, s_drd, s_idok, s_ird} !== {1'b1, (dwr ? 32'h0 : rd), 1'b0, 32'h0}) begin
          n_bad++; $display("FAIL rand_resp_%0d: got d=%b/%h i=%b/%h want d=1/%h i=0/0", t, s_ddok, s_drd, s_idok, s_ird, (dwr ? 32'h0 : rd));
        end
        pd = 1'b0;
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_inst_read();
    test_write_priority();
    test_starvation();
    test_flush_addr();
    test_flush_wait();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
